// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared types and constants for the UART transmit driver:
//               the transmit FSM state encoding, the data-bit index width
//               and the idle line level.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  // Transmit FSM states. ST_PARITY is only reachable when the parity
  // feature is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int                    BIT_IDX_W    = 3;
  localparam logic [BIT_IDX_W-1:0]  BIT_IDX_LAST = 3'd7;

  // The line rests high between frames and during stop bits.
  localparam logic                  IDLE_LEVEL   = 1'b1;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Free-running bit-period counter. Counts 0..BIT_CYCLES-1 and
//               pulses bit_done on the terminal count, then restarts. A clear
//               forces the count back to zero so the owning FSM can align
//               the first bit period to a state entry.
// Ports       : g_clk    - system clock, rising edge
//               g_resetn - synchronous reset, active-low
//               clear    - restart the bit period
//               bit_done - high during the last cycle of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int BIT_CYCLES = 434
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic clear,
  output logic bit_done
);

  localparam int               CNT_W    = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_done = (cnt == CNT_LAST);

  // Terminal count restarts the period, so the counter never wraps on its own.
  always_ff @(posedge g_clk) begin
    if (!g_resetn || clear || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_tx_driver.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_driver
// Description : UART transmitter with a valid/ready byte input, a one-entry
//               holding buffer and a bit-timed shift FSM. A byte held while a
//               frame is on the line starts immediately after the last stop
//               cycle, so frames can run back-to-back with no idle gap.
//               Optional parity bit: compile with UART_TX_PARITY_EN defined.
// Ports       : g_clk    - system clock, rising edge
//               g_resetn - synchronous reset, active-low
//               tx_valid - byte offered on tx_data
//               tx_ready - holding buffer empty (accept on valid & ready)
//               tx_data  - byte to send, LSB first
//               tx_busy  - frame in progress or byte held
//               uart_txd - registered serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_driver
  import uart_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 434,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       g_clk,
  input  logic       g_resetn,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       uart_txd
);

  // Index of the final stop bit (stop counter is one bit: 1 or 2 stop bits).
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  tx_state_t            state;
  logic                 running;      // low during reset, high from first edge after release
  logic                 hold_valid;
  logic [7:0]           hold_data;
  logic [7:0]           shift;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic                 stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;   // captured from the whole byte at load
`endif

  logic bit_done;
  logic timer_clear;
  logic accept;
  logic stop_final;
  logic load_now;

  // Every non-IDLE transition happens on bit_done, which already restarts the
  // timer; holding it clear while IDLE aligns the first START period.
  assign timer_clear = (state == ST_IDLE);

  uart_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .clear    (timer_clear),
    .bit_done (bit_done)
  );

  assign tx_ready   = running & ~hold_valid;
  assign tx_busy    = (state != ST_IDLE) | hold_valid;
  assign accept     = tx_valid & tx_ready;
  assign stop_final = (state == ST_STOP) & bit_done & (stop_cnt == STOP_LAST);
  // Accept and unload are mutually exclusive: accept needs an empty buffer,
  // load needs a full one.
  assign load_now   = hold_valid & ((state == ST_IDLE) | stop_final);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      shift      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      uart_txd   <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      running <= 1'b1;

      // The line is registered from the current state, so it trails the
      // state register by one cycle but keeps each level for a full period.
      case (state)
        ST_START:  uart_txd <= 1'b0;
        ST_DATA:   uart_txd <= shift[0];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: uart_txd <= parity_bit;
`endif
        default:   uart_txd <= IDLE_LEVEL;
      endcase

      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_data;
      end

      if (load_now) begin
        shift      <= hold_data;
        hold_valid <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_bit <= (^hold_data) ^ PARITY_ODD;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (hold_valid) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == BIT_IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
              stop_cnt <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            state    <= ST_STOP;
            stop_cnt <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          if (bit_done) begin
            if (stop_cnt == STOP_LAST) begin
              // A held byte goes straight into its start bit: no idle gap.
              state <= hold_valid ? ST_START : ST_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : uart_tx_driver
`default_nettype wire

// File: tb/tb_uart_tx_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_driver
// Description : Self-checking bench for uart_tx_driver. Instance dut drives a
//               single-stop-bit line decoded by a frame monitor against a byte
//               scoreboard; instance dut2 uses two stop bits and odd parity
//               and is compared cycle-by-cycle against a line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_driver;

  localparam int BC    = 4;
  localparam bit PODD1 = 1'b0;
  localparam bit PODD2 = 1'b1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB1    = 1 + 8 + P + 1;
  localparam int NB2    = 1 + 8 + P + 2;
  localparam int FRAME  = NB1 * BC;
  localparam int FRAME2 = NB2 * BC;

  logic       clk;
  logic       g_resetn;
  logic       tx_valid, tx_ready, tx_busy, txd;
  logic [7:0] tx_data;
  logic       d2_valid, d2_ready, d2_busy, d2_txd;
  logic [7:0] d2_data;

  int         cyc;
  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  int         starts[$];

  uart_tx_driver #(.BIT_CYCLES(BC), .STOP_BITS(1), .PARITY_ODD(PODD1)) dut (
    .g_clk    (clk),
    .g_resetn (g_resetn),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .uart_txd (txd)
  );

  uart_tx_driver #(.BIT_CYCLES(BC), .STOP_BITS(2), .PARITY_ODD(PODD2)) dut2 (
    .g_clk    (clk),
    .g_resetn (g_resetn),
    .tx_valid (d2_valid),
    .tx_ready (d2_ready),
    .tx_data  (d2_data),
    .tx_busy  (d2_busy),
    .uart_txd (d2_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic int pop_start();
    if (starts.size() == 0) return -1;
    return starts.pop_front();
  endfunction

  // Expected line bits of one frame, bit 0 first; unused upper bits idle high.
  function automatic logic [15:0] frame_bits(input logic [7:0] b, input logic podd);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (P == 1) f[9] = (^b) ^ podd;
    return f;
  endfunction

  // Call at a negedge. Returns #1 after the accepting edge with tx_valid
  // still high so a following call can offer the next byte back-to-back.
  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    n        = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      chk("ready_timeout", tx_ready, 1);
      acc = -1;
    end else begin
      acc = cyc + 1;
      exp_q.push_back(b);
      @(posedge clk);
      #1;
    end
  endtask

  // Frame monitor: detect a start edge, sample each bit mid-period, pop the
  // scoreboard. A reset seen inside a frame abandons it without popping.
  initial begin : monitor
    logic       prev;
    logic       smp [16];
    logic       ab;
    logic       stops_ok;
    logic [7:0] got;
    logic [7:0] want;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (g_resetn && prev && !txd) begin
        starts.push_back(cyc);
        ab = 1'b0;
        for (int k = 0; k < 16; k++) smp[k] = 1'b1;
        for (int c = 1; c <= (NB1 - 1) * BC + BC / 2; c++) begin
          @(negedge clk);
          if (!g_resetn) ab = 1'b1;
          if (!ab && (c % BC) == BC / 2) smp[c / BC] = txd;
        end
        if (!ab) begin
          for (int k = 0; k < 8; k++) got[k] = smp[k + 1];
          stops_ok = smp[NB1 - 1];
          chk("frame_expected", (exp_q.size() != 0), 1);
          want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          chk("start_bit", smp[0], 0);
          chk("frame_byte", got, want);
          chk("stop_bit", stops_ok, 1);
          if (P == 1) chk("parity_bit", smp[9], (^want) ^ PODD1);
        end
      end
      prev = txd;
    end
  end

  initial begin : main
    int a, b, a1, a2, a3;
    tx_valid = 1'b0; tx_data = '0;
    d2_valid = 1'b0; d2_data = '0;
    g_resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 0);
    chk("rst_busy", tx_busy, 0);
    g_resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);

    // Single byte from idle.
    send_byte(8'h55, a);
    tx_valid = 1'b0;
    @(negedge clk); chk("t1_ready_drop", tx_ready, 0);
    @(negedge clk); chk("t1_ready_back", tx_ready, 1);
    wait_cyc(a + FRAME);     chk("t1_busy_end", tx_busy, 1);
    @(negedge clk);          chk("t1_busy_idle", tx_busy, 0);
    wait_cyc(a + FRAME + 4); chk("t1_start", pop_start(), a + 2);

    // Back-to-back pair.
    send_byte(8'hA5, a);
    send_byte(8'h3C, b);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("t2_accept2", b, a + 2);
    wait_cyc(a + 2 * FRAME + 4);
    chk("t2_start1", pop_start(), a + 2);
    chk("t2_start2", pop_start(), a + 2 + FRAME);
    chk("t2_busy_idle", tx_busy, 0);

    // Backpressure: third byte waits for the second frame to start.
    send_byte(8'h01, a1);
    send_byte(8'h80, a2);
    send_byte(8'hFF, a3);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("t3_accept2", a2, a1 + 2);
    chk("t3_accept3", a3, a1 + 2 + FRAME);
    wait_cyc(a1 + 3 * FRAME + 4);
    chk("t3_start1", pop_start(), a1 + 2);
    chk("t3_start2", pop_start(), a1 + 2 + FRAME);
    chk("t3_start3", pop_start(), a1 + 2 + 2 * FRAME);

    // Reset during data bit 3 of 0xF0 with 0x0F held.
    send_byte(8'hF0, a);
    send_byte(8'h0F, b);
    tx_valid = 1'b0;
    @(negedge clk);
    wait_cyc(a + 2 + 4 * BC + 1);
    g_resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_txd_high", txd, 1);
    chk("t4_ready_low", tx_ready, 0);
    chk("t4_busy_low", tx_busy, 0);
    @(negedge clk);
    g_resetn = 1'b1;
    @(negedge clk);
    chk("t4_ready_back", tx_ready, 1);
    chk("t4_start", pop_start(), a + 2);
    repeat (2 * FRAME + BC) @(negedge clk);
    chk("t4_no_frame", starts.size(), 0);

    // Parity-sensitive byte after reset recovery.
    send_byte(8'h07, a);
    tx_valid = 1'b0;
    @(negedge clk);
    wait_cyc(a + FRAME + 4);
    chk("t5_start", pop_start(), a + 2);

    // Two stop bits, odd parity: whole-line comparison of 0x00 then held 0x81.
    @(negedge clk);
    chk("d2_ready", d2_ready, 1);
    d2_valid = 1'b1;
    d2_data  = 8'h00;
    a        = cyc + 1;
    fork
      begin : d2_drv
        int n;
        @(posedge clk);
        #1 d2_data = 8'h81;
        n = 0;
        while (!d2_ready && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("d2_accept2", d2_ready, 1);
        @(posedge clk);
        #1 d2_valid = 1'b0;
      end
      begin : d2_chk
        int          mism;
        int          f;
        logic        want;
        logic [15:0] fb [2];
        fb[0] = frame_bits(8'h00, PODD2);
        fb[1] = frame_bits(8'h81, PODD2);
        mism  = 0;
        for (int c = -1; c <= 2 * FRAME2; c++) begin
          wait_cyc(a + 2 + c);
          if (c < 0) begin
            want = 1'b1;
          end else begin
            f    = c / FRAME2;
            want = (f >= 2) ? 1'b1 : fb[f][(c % FRAME2) / BC];
          end
          if (d2_txd !== want) mism++;
        end
        chk("d2_wave", mism, 0);
        chk("d2_busy_idle", d2_busy, 0);
      end
    join

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
  end

endmodule : tb_uart_tx_driver
`default_nettype wire

// File: doc/uart_tx_driver.md
Name: uart_tx_driver

Overview:
- Synthesizable UART transmitter that serialises bytes onto a line feeding the SoC's `uart_rxd` input.
- This is the opposite direction to the SoC UART output `uart_txd`.
- Used in the Xilinx verification top to drive stimulus into the design, and reusable as an on-chip TX engine.
- Has a valid/ready byte input, a one-entry holding buffer and a bit-timed shift FSM, so frames can be sent back-to-back with no idle gap.

Parameters:
- BIT_CYCLES, 434, g_clk cycles per UART bit (minimum 2).
- STOP_BITS, 1, number of stop bits (1 or 2).
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- g_clk  in  1  system clock; all state updates on rising edge.
- g_resetn  in  1  synchronous reset, active-low.
- tx_valid  in  1  byte offered on tx_data.
- tx_ready  out  1  holding buffer empty; byte accepted when tx_valid & tx_ready at a rising edge.
- tx_data  in  8  byte to send, LSB first.
- tx_busy  out  1  frame in progress or byte held.
- uart_txd  out  1  serial line, registered, idle high.

Behaviour:
- Reset (g_resetn low at an edge):
  - uart_txd=1, tx_ready=0, tx_busy=0.
  - Holding buffer emptied, FSM in IDLE, counters cleared.
  - tx_ready rises on the first edge after release.
- tx_ready = !hold_valid while out of reset. A byte is never accepted while one is held; no same-cycle accept and unload.
- FSM states: IDLE, START, DATA, PARITY (only if compiled in), STOP.
- Bit counter runs 0..BIT_CYCLES-1 and is $clog2(BIT_CYCLES) bits wide. Each state's line value is held for exactly BIT_CYCLES cycles.
- Bit index is 0..7 in DATA.
- IDLE:
  - uart_txd=1.
  - If hold_valid: load the shift register from hold, clear hold_valid, go to START.
- Latency: byte accepted at edge N (IDLE, buffer empty) -> hold loaded at N -> shifter loads at N+1 -> uart_txd=0 from edge N+2.
- START: txd=0 for BIT_CYCLES, then DATA.
- DATA: txd=shift[0]; shift right after each bit. After bit 7, go to PARITY or STOP.
- STOP: txd=1 for STOP_BITS*BIT_CYCLES. On its final cycle:
  - hold_valid=1 -> load shifter, clear hold, go directly to START. The next start bit begins on the cycle immediately after the last stop cycle; no idle gap.
  - else -> IDLE.
- Frame length in cycles = (1 + 8 + P + STOP_BITS) * BIT_CYCLES, where P = 1 with parity, else 0.
- A new byte may be accepted at any point during a frame; it is held unchanged until the next frame start.
- tx_busy = (state != IDLE) | hold_valid.
- tx_data is sampled only at the accept edge; later changes have no effect.
- Reset mid-frame:
  - uart_txd returns high on that edge; the frame is truncated.
  - The held byte is discarded.
- Counters never wrap outside their terminal counts; bit index saturates at 7 until the state exits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA bit 7.
  - txd = ^byte ^ PARITY_ODD for BIT_CYCLES.
  - The parity bit is computed from the byte at shifter load, not from the shifted remainder.
- Undefined:
  - No PARITY state; DATA goes straight to STOP.
  - PARITY_ODD is ignored.
  - No parity logic synthesised.

Decomposition:
- Package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - Width constant for the bit index (3).
  - Idle line level constant (1'b1).
- Sub-module uart_bit_timer:
  - Parameter BIT_CYCLES.
  - Inputs: g_clk, g_resetn, clear.
  - Output: bit_done, a pulse on the terminal count.
  - Restarts on clear or when bit_done fires.
  - The FSM clears it on every state entry.

Test Plan (BIT_CYCLES=4, STOP_BITS=1, parity off unless stated):
- Single byte 0x55 offered one cycle from idle:
  - tx_ready drops for 1 cycle.
  - uart_txd goes low 2 cycles after accept.
  - 4-cycle bits follow: 0,1,0,1,0,1,0,1,0,1.
  - Line returns high after 40 cycles; tx_busy falls with the return to IDLE.
- Back-to-back 0xA5 then 0x3C, tx_valid held high:
  - Second byte accepted while the first is shifting.
  - Start bit of 0x3C follows the 0xA5 stop bit with no gap.
  - Both frames total 80 cycles of activity.
- Backpressure: offer 3 bytes continuously. The third sees tx_ready=0 until the second frame starts.
  - All three are serialised in order: 0x01, 0x80, 0xFF.
- Reset mid-frame:
  - Assert g_resetn=0 during bit 3 of 0xF0, with 0x0F held.
  - uart_txd=1 on the next edge; 0x0F is never transmitted.
  - tx_ready=1 one edge after release.
- UART_TX_PARITY_EN, PARITY_ODD=0, byte 0x07: parity bit 1; frame is 44 cycles.
  - Same test with PARITY_ODD=1: parity bit 0.
- STOP_BITS=2, byte 0x00: line high for 8 cycles after data bit 7.
  - A held byte starts its frame immediately after those 8 cycles.
